// File: rtl/mem_read_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_read_pkg                                                               |
// | Shared types and encodings for the memory read port.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_read_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAPT = 2'd2
  } state_e;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam int unsigned TIMEOUT_CYC_DEF = 255;

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// +----------------------------------------------------------------------------+
// | load_align                                                                 |
// | Selects the addressed byte/half lane of a memory word and extends it.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_align
  import mem_read_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] result_o
);

  logic [15:0] lane_h;
  logic [7:0]  lane_b;

  assign lane_h = off_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    lane_b = word_i[7:0];
    case (off_i)
      2'd1:    lane_b = word_i[15:8];
      2'd2:    lane_b = word_i[23:16];
      2'd3:    lane_b = word_i[31:24];
      default: lane_b = word_i[7:0];
    endcase
  end

  // Reserved size 2'b11 behaves as a full word.
  always_comb begin
    result_o = word_i;
    case (size_i)
      SZ_HALF: result_o = {{16{signed_i & lane_h[15]}}, lane_h};
      SZ_BYTE: result_o = {{24{signed_i & lane_b[7]}}, lane_b};
      SZ_WORD: result_o = word_i;
      default: result_o = word_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_read_port.sv
// +----------------------------------------------------------------------------+
// | mem_read_port                                                              |
// | Load port: req/ack read of a variable-latency memory, aligned result in an |
// | MDR-style register. Optional request timeout: MEM_READ_TIMEOUT_EN.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_read_port
  import mem_read_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] RDATA_RST = 32'h0
`ifdef MEM_READ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              err
);

  state_e              state_q, state_d;
  logic [ADDR_W-3:0]   waddr_q, waddr_d;
  logic [1:0]          off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic [31:0]         buf_q, buf_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         aligned;
  logic                timed_out;

`ifdef MEM_READ_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // err is only ever set on the REQ->CAPT timeout edge, so in CAPT it marks an aborted load.
  assign timed_out = err_q;
  assign err       = err_q;
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  load_align u_align (
    .word_i   (buf_q),
    .off_i    (off_q),
    .size_i   (size_q),
    .signed_i (sgn_q),
    .result_o (aligned)
  );

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == CAPT);
  assign mem_req  = (state_q == REQ);
  assign mem_addr = {waddr_q, 2'b00};

  // New data is presented in the done cycle itself and retained afterwards.
  always_comb begin
    rdata_d = rdata_q;
    if ((state_q == CAPT) && !timed_out) begin
      rdata_d = aligned;
    end
  end

  assign rdata = rdata_d;

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    off_d   = off_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    buf_d   = buf_q;
`ifdef MEM_READ_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          waddr_d = addr[ADDR_W-1:2];
          off_d   = addr[1:0];
          size_d  = ld_size;
          sgn_d   = ld_signed;
          state_d = REQ;
`ifdef MEM_READ_TIMEOUT_EN
          cnt_d   = 8'd0;
          err_d   = 1'b0;
`endif
        end
      end
      REQ: begin
        if (mem_ack) begin
          buf_d   = mem_rdata;
          state_d = CAPT;
`ifdef MEM_READ_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          state_d = CAPT;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      CAPT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      waddr_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      buf_q   <= '0;
      rdata_q <= RDATA_RST;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_READ_TIMEOUT_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_read_port.sv
// +----------------------------------------------------------------------------+
// | tb_mem_read_port                                                           |
// | Scoreboard bench for mem_read_port (covers MEM_READ_TIMEOUT_EN if defined).|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_read_port;
  import mem_read_pkg::*;

  localparam logic [31:0] RST_VAL = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  ld_size = '0;
  logic        ld_signed = 1'b0;
  logic        busy, done, mem_req, err;
  logic [31:0] rdata, mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          done_at;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_r = RST_VAL;

  mem_read_port #(
    .ADDR_W    (32),
    .RDATA_RST (RST_VAL)
`ifdef MEM_READ_TIMEOUT_EN
    , .TIMEOUT_CYC (4)
`endif
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .addr      (addr),
    .ld_size   (ld_size),
    .ld_signed (ld_signed),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each expected completion is retired at its due cycle or on done.
  always @(negedge clk) begin
    if (sb.size() > 0 && (done || cyc >= sb[0].done_at)) begin
      exp_t e;
      e = sb.pop_front();
      chk("done_cycle", cyc, e.done_at);
      chk("done", {31'd0, done}, 32'd1);
      chk("rdata", rdata, e.rdata);
      chk("err", {31'd0, err}, {31'd0, e.err});
    end else if (done) begin
      chk("done_spurious", {31'd0, done}, 32'd0);
    end
  end

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                         input logic [31:0] w, input int waits, input logic [31:0] exp_r,
                         input bit restart_in_done);
    sb.push_back('{rdata: exp_r, err: 1'b0, done_at: cyc + 2 + waits});
    last_r    = exp_r;
    start     = 1'b1;
    addr      = a;
    ld_size   = sz;
    ld_signed = sg;
    step();
    start = 1'b0;
    chk("req_busy", {31'd0, busy}, 32'd1);
    chk("mem_req", {31'd0, mem_req}, 32'd1);
    chk("mem_addr", mem_addr, {a[31:2], 2'b00});
    chk("err_clear", {31'd0, err}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      start     = i[0];
      addr      = 32'hFFFF_FFFF;
      ld_size   = SZ_BYTE;
      ld_signed = ~sg;
      step();
      chk("req_hold", {31'd0, mem_req}, 32'd1);
    end
    start     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = w;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0BAD_F00D;
    chk("req_drop", {31'd0, mem_req}, 32'd0);
    if (restart_in_done) begin
      start = 1'b1;
      addr  = 32'h0000_0300;
    end
    step();
    start = 1'b0;
    chk("idle_req", {31'd0, mem_req}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_rdata", rdata, RST_VAL);
    chk("rst_err", {31'd0, err}, 32'd0);
    clr = 1'b1;
    step();

    // Reset mid-REQ abandons the request; later acks are ignored
    start   = 1'b1;
    addr    = 32'h0000_0100;
    ld_size = SZ_WORD;
    step();
    start = 1'b0;
    chk("arst_pre_req", {31'd0, mem_req}, 32'd1);
    step();
    step();
    #2 clr = 1'b0;
    #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_maddr", mem_addr, 32'd0);
    chk("arst_rdata", rdata, RST_VAL);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_1111;
    step();
    clr = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    chk("stray_ack_req", {31'd0, mem_req}, 32'd0);
    chk("stray_ack_rdata", rdata, RST_VAL);

    // Functional loads
    do_load(32'h0000_0040, SZ_WORD, 1'b0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0);
    do_load(32'h0000_0043, SZ_BYTE, 1'b1, 32'h8012_3456, 1, 32'hFFFF_FF80, 1'b0);
    do_load(32'h0000_0043, SZ_BYTE, 1'b0, 32'h8012_3456, 0, 32'h0000_0080, 1'b0);
    do_load(32'h0000_0022, SZ_HALF, 1'b0, 32'hBEEF_1234, 5, 32'h0000_BEEF, 1'b0);
    do_load(32'h0000_0026, SZ_HALF, 1'b1, 32'h8001_1234, 2, 32'hFFFF_8001, 1'b0);
    do_load(32'h0000_0051, SZ_BYTE, 1'b0, 32'h1234_5678, 0, 32'h0000_0056, 1'b0);
    do_load(32'h0000_0063, 2'b11,   1'b1, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1'b0);

    // Back-to-back: start in done cycle ignored, next cycle accepted
    do_load(32'h0000_0080, SZ_HALF, 1'b1, 32'h8000_7FFF, 0, 32'h0000_7FFF, 1'b1);
    do_load(32'h0000_0084, SZ_BYTE, 1'b1, 32'h1234_56F0, 0, 32'hFFFF_FFF0, 1'b0);

`ifdef MEM_READ_TIMEOUT_EN
    // Ack on the timeout cycle wins
    do_load(32'h0000_0104, SZ_WORD, 1'b0, 32'h0F0F_0F0F, 3, 32'h0F0F_0F0F, 1'b0);
    // No ack: abort after 4 REQ cycles, rdata retained, sticky err
    sb.push_back('{rdata: last_r, err: 1'b1, done_at: cyc + 5});
    start   = 1'b1;
    addr    = 32'h0000_0200;
    ld_size = SZ_WORD;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_req", {31'd0, mem_req}, 32'd1);
      step();
    end
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_err", {31'd0, err}, 32'd1);
    step();
    chk("to_err_sticky", {31'd0, err}, 32'd1);
    chk("to_rdata_kept", rdata, last_r);
    do_load(32'h0000_0208, SZ_BYTE, 1'b0, 32'hA1B2_C3D4, 0, 32'h0000_00D4, 1'b0);
`else
    // Long wait with no timeout logic
    do_load(32'h0000_1000, SZ_WORD, 1'b0, 32'h0F0F_0F0F, 12, 32'h0F0F_0F0F, 1'b0);
    chk("no_err", {31'd0, err}, 32'd0);
`endif

    repeat (3) step();
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
